// File: rtl/mem_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_ctrl
// Description : Command-driven controller sequencing single/burst reads,
//               writes, fills and incrementing patterns onto a synchronous
//               single-port memory. Optional macro MEM_IF_ERR_EN makes
//               illegal OP codes complete with an err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_if_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        OP,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] Base,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] Wdata,
    output logic [ADDR_W-1:0] Direction,
    output logic [DATA_W-1:0] Data,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_RD   = 3'b001;
    localparam logic [2:0] OP_WR   = 3'b010;
    localparam logic [2:0] OP_BRD  = 3'b011;
    localparam logic [2:0] OP_FILL = 3'b100;
    localparam logic [2:0] OP_PAT  = 3'b101;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              rv_q, rv_d;
    logic              done_q, done_d;
    logic [LEN_W:0]    idx_q, idx_d;
    logic [LEN_W:0]    last_q, last_d;
    logic              pat_q, pat_d;
`ifdef MEM_IF_ERR_EN
    logic              err_q, err_d;
`endif
    logic              w_hs;

    assign cmd_ready = (state_q == IDLE) & ~reset;
    assign w_hs      = cmd_valid & cmd_ready;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        data_d  = data_q;
        we_d    = we_q;
        re_d    = re_q;
        rv_d    = re_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        last_d  = last_q;
        pat_d   = pat_q;
`ifdef MEM_IF_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    idx_d  = '0;
                    pat_d  = (OP == OP_PAT);
                    // Single ops always run exactly one beat regardless of Len
                    last_d = (OP == OP_RD || OP == OP_WR) ? '0 : {1'b0, Len};
                    case (OP)
                        OP_RD, OP_BRD: begin
                            state_d = BUSY;
                            re_d    = 1'b1;
                            dir_d   = Base;
                        end
                        OP_WR, OP_FILL, OP_PAT: begin
                            state_d = BUSY;
                            we_d    = 1'b1;
                            dir_d   = Base;
                            data_d  = Wdata;
                        end
`ifdef MEM_IF_ERR_EN
                        3'b110, 3'b111: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (idx_q == last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    dir_d   = '0;
                    data_d  = '0;
                end else begin
                    idx_d = idx_q + (LEN_W + 1)'(1);
                    dir_d = dir_q + ADDR_W'(1);
                    if (pat_q) begin
                        data_d = data_q + DATA_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            pat_q   <= 1'b0;
`ifdef MEM_IF_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
`ifdef MEM_IF_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Direction = dir_q;
    assign Data      = data_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign rd_valid  = rv_q;
    assign rd_data   = rv_q ? mem_rdata : '0;
    assign done      = done_q;
`ifdef MEM_IF_ERR_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_if_ctrl
// Description : Self-checking bench for mem_if_ctrl with a memory model and a
//               per-cycle reference of the command timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_if_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  OP;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] Base;
    logic [7:0]  Len;
    logic [7:0]  Wdata;
    logic [19:0] Direction;
    logic [7:0]  Data;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_if_ctrl #(.ADDR_W(20), .DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .OP(OP), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .Base(Base), .Len(Len), .Wdata(Wdata),
        .Direction(Direction), .Data(Data), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err)
    );

    // Physical memory driven by the DUT, and the bench's expected contents
    logic [7:0] mem     [logic [19:0]];
    logic [7:0] ref_mem [logic [19:0]];

    function automatic logic [7:0] mem_get(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_get(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[Direction] = Data;
        if (mem_re) mem_rdata <= mem_get(Direction);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [41:0] dut_vec();
        return {cmd_ready, Direction, Data, mem_we, mem_re, rd_data, rd_valid, done, err};
    endfunction

    function automatic bit is_err_op(input logic [2:0] op);
`ifdef MEM_IF_ERR_EN
        return op >= 3'd6;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int beats_of(input logic [2:0] op, input logic [7:0] len);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op >= 3'd3 && op <= 3'd5) return int'(len) + 1;
        return 0;
    endfunction

    function automatic int done_of(input logic [2:0] op, input logic [7:0] len);
        if (beats_of(op, len) > 0) return beats_of(op, len) + 1;
        return is_err_op(op) ? 1 : 0;
    endfunction

    // Issues one command from an idle negedge and checks every cycle until idle again
    task automatic run_cmd(input logic [2:0] op, input logic [19:0] base, input logic [7:0] len,
                           input logic [7:0] wd, input int exp_beats, input int exp_done,
                           output logic [7:0] last_rd);
        bit rd, wr, legal, errc;
        int n, lim, beats, done_at;
        logic        e_we, e_re, e_rv, e_done, e_err, e_rdy;
        logic [19:0] e_dir;
        logic [7:0]  e_data, e_rd;
        rd    = (op == 3'd1 || op == 3'd3);
        wr    = (op == 3'd2 || op == 3'd4 || op == 3'd5);
        legal = rd || wr;
        errc  = is_err_op(op);
        n     = (op == 3'd1 || op == 3'd2) ? 1 : int'(len) + 1;
        lim   = legal ? n + 2 : (errc ? 2 : 3);
        check("ready_before", {63'd0, cmd_ready}, 64'd1);
        OP = op; Base = base; Len = len; Wdata = wd; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        beats = 0; done_at = 0; last_rd = 8'h00;
        for (int k = 1; k <= lim; k++) begin
            e_we   = wr && k <= n;
            e_re   = rd && k <= n;
            e_dir  = (e_we || e_re) ? 20'(base + 20'(k - 1)) : 20'h0;
            e_data = e_we ? ((op == 3'd5) ? 8'(wd + 8'(k - 1)) : wd) : 8'h00;
            e_rv   = rd && k >= 2 && k <= n + 1;
            e_rd   = e_rv ? ref_get(20'(base + 20'(k - 2))) : 8'h00;
            e_done = legal ? (k == n + 1) : (errc && k == 1);
            e_err  = errc && k == 1;
            e_rdy  = legal ? (k == n + 2) : (errc ? (k == 2) : 1'b1);
            check($sformatf("cyc op%0d k%0d", op, k), {22'd0, dut_vec()},
                  {22'd0, e_rdy, e_dir, e_data, e_we, e_re, e_rd, e_rv, e_done, e_err});
            if (mem_we || mem_re) beats++;
            if (done && done_at == 0) done_at = k;
            if (rd_valid) last_rd = rd_data;
            if (e_we) ref_mem[e_dir] = e_data;
            if (k < lim) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check($sformatf("beats op%0d", op), 64'(beats), 64'(exp_beats));
        check($sformatf("done_at op%0d", op), 64'(done_at), 64'(exp_done));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [19:0] base;
        logic [7:0]  len;
        logic [7:0]  wd;
        int          beats;
        int          done_at;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[9];
        logic [7:0]  lr;
        int          we_cnt;
        int          e_err_done;
        e_err_done = is_err_op(3'd7) ? 1 : 0;
        vecs[0] = '{3'b010, 20'h00010, 8'd0,   8'hA5, 1,   2};
        vecs[1] = '{3'b001, 20'h00010, 8'd5,   8'h00, 1,   2};
        vecs[2] = '{3'b011, 20'h00100, 8'd3,   8'h00, 4,   5};
        vecs[3] = '{3'b101, 20'hFFFFE, 8'd3,   8'hFE, 4,   5};
        vecs[4] = '{3'b100, 20'h02000, 8'd255, 8'h5A, 256, 257};
        vecs[5] = '{3'b000, 20'h00055, 8'd3,   8'h00, 0,   0};
        vecs[6] = '{3'b111, 20'h00077, 8'd2,   8'h00, 0,   e_err_done};
        vecs[7] = '{3'b110, 20'h00078, 8'd2,   8'h00, 0,   e_err_done};
        vecs[8] = '{3'b011, 20'hFFFFE, 8'd3,   8'h00, 4,   5};

        for (int a = 0; a < 4; a++) begin
            mem[20'h100 + 20'(a)]     = 8'(8'h11 * (a + 1));
            ref_mem[20'h100 + 20'(a)] = 8'(8'h11 * (a + 1));
        end

        reset = 1'b1; cmd_valid = 1'b0; OP = 3'd0; Base = 20'd0; Len = 8'd0; Wdata = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {22'd0, dut_vec()}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {22'd0, dut_vec()}, {22'd0, 1'b1, 41'd0});

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].base, vecs[i].len, vecs[i].wd,
                    vecs[i].beats, vecs[i].done_at, lr);
            if (i == 1) check("single_read_data", 64'(lr), 64'hA5);
            if (i == 2) check("burst_last_data", 64'(lr), 64'h44);
            if (i == 8) check("wrap_read_data", 64'(lr), 64'h01);
        end
        check("pattern_wrap_mem", 64'(mem_get(20'h00001)), 64'h01);

        // Held cmd_valid: single writes accepted every third cycle
        OP = 3'b010; Base = 20'h00040; Len = 8'd0; Wdata = 8'h3C; cmd_valid = 1'b1;
        we_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (c == 8) cmd_valid = 1'b0;
        end
        check("held_cmd_writes", 64'(we_cnt), 64'd3);
        ref_mem[20'h00040] = 8'h3C;
        repeat (3) @(negedge clk);
        check("held_cmd_idle", {22'd0, dut_vec()}, {22'd0, 1'b1, 41'd0});

        // Reset in the middle of an 8-beat burst read
        OP = 3'b011; Base = 20'h00300; Len = 8'd7; Wdata = 8'h00; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_beat0", {43'd0, mem_re, Direction}, {43'd0, 1'b1, 20'h00300});
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_cleared", {22'd0, dut_vec()}, 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_quiet", {22'd0, dut_vec()}, {22'd0, 1'b1, 41'd0});
        end
        run_cmd(3'b010, 20'h00500, 8'd0, 8'h77, 1, 2, lr);

        // Randomized commands against the reference rules
        for (int r = 0; r < 40; r++) begin
            logic [2:0]  rop;
            logic [19:0] rbase;
            logic [7:0]  rlen;
            logic [7:0]  rwd;
            rop   = 3'($urandom_range(0, 7));
            rbase = ($urandom_range(0, 3) == 0) ? 20'(20'hFFFF0 + 20'($urandom_range(0, 15)))
                                                : 20'($urandom_range(0, 255));
            rlen  = 8'($urandom_range(0, 15));
            rwd   = 8'($urandom);
            run_cmd(rop, rbase, rlen, rwd, beats_of(rop, rlen), done_of(rop, rlen), lr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_if_ctrl.md
# mem_if_ctrl

- Parametrised memory-interface controller, successor to the fixed 20-bit-address / 8-bit-data interface top.
- Accepts one command per valid/ready handshake: OP code, base address, beat count.
- Sequences single or burst accesses onto a synchronous single-port memory (`Direction`, `Data`, strobes) and returns read data with a valid flag.
- Sits between the system command source and the external memory model.

## Interface

Parameters:
- `ADDR_W`, 20, width of `Base` and `Direction`
- `DATA_W`, 8, width of all data buses
- `LEN_W`, 8, width of `Len`; burst beats = `Len` + 1 (1..2^LEN_W)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge
- `OP`  in  3  command code; sampled on handshake
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `Base`  in  ADDR_W  start address; sampled on handshake
- `Len`  in  LEN_W  beats minus one; sampled on handshake; ignored for single ops
- `Wdata`  in  DATA_W  write/fill seed; sampled on handshake
- `Direction`  out  ADDR_W  memory address
- `Data`  out  DATA_W  memory write data
- `mem_we`  out  1  write strobe, one beat per cycle
- `mem_re`  out  1  read strobe, one beat per cycle
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_re`
- `rd_data`  out  DATA_W  read data to requester; equals `mem_rdata` when `rd_valid`=1, else 0
- `rd_valid`  out  1  `mem_re` delayed one cycle
- `done`  out  1  one-cycle pulse at command completion
- `err`  out  1  one-cycle pulse with `done` for an illegal OP

## Operation

- **OP codes:**
  - 000 NOP
  - 001 single read
  - 010 single write of `Wdata`
  - 011 burst read
  - 100 fill: every beat writes `Wdata`
  - 101 pattern: beat i writes `Wdata` + i, mod 2^DATA_W
  - 110/111 illegal
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE→BUSY on handshake with a non-NOP legal OP.
  - BUSY→DONE after the last beat.
  - DONE→IDLE unconditionally.
  - NOP: accepted; state stays IDLE; no `done`.
- **Handshake and strobes:**
  - Handshake occurs when `cmd_valid` & `cmd_ready`.
  - `cmd_ready` = (state==IDLE) & !`reset`.
  - `mem_we` and `mem_re` are never both high.
- **Addressing:**
  - Beat i drives `Direction` = `Base` + i mod 2^ADDR_W; addresses wrap from all-ones to 0.
  - Beat counter is LEN_W+1 bits wide.
- **Idle output values:** `Direction` = 0 and `Data` = 0 whenever both strobes are low. `Data` = 0 during reads.
- **Reset:**
  - Next edge forces state IDLE and clears all registered outputs.
  - Reset in the middle of a burst abandons the burst: no further strobes, no `done`.
  - Values on reset: `cmd_ready`=0 while `reset`=1; all other outputs 0.

## Timing

- **Command accepted at edge T, N beats:**
  - Strobe and address for beat i are high in cycle T+1+i, for i = 0..N-1.
  - `rd_valid` is high in cycles T+2..T+N+1.
  - DONE occupies cycle T+N+1: `done`=1, coincident with the last `rd_valid` for reads.
  - `cmd_ready`=1 again in cycle T+N+2.
- **Single ops:** N=1, so `done` is in T+2.
- **Throughput:** strobes are back-to-back; no bubbles inside a burst. Minimum gap between accepted commands is N+2 cycles.
- **Held commands:** `cmd_valid` held high during BUSY/DONE is not accepted; it is accepted in the first IDLE cycle.

## Configuration

- **`MEM_IF_ERR_EN` defined:**
  - OP 110/111 is accepted and moves IDLE→DONE.
  - No strobes are issued.
  - `done`=1 and `err`=1 in cycle T+1.
  - `cmd_ready`=1 in cycle T+2.
- **`MEM_IF_ERR_EN` undefined:**
  - OP 110/111 behaves exactly as NOP.
  - `err` is tied to 0.

## Test plan

- **Single write then read:**
  - Stimulus: OP=010, `Base`=0x00010, `Wdata`=0xA5; then OP=001 at the same `Base`.
  - Response: `mem_we` for 1 cycle at 0x00010; `done` at T+2; read returns `rd_data`=0xA5 with `rd_valid` at T+2.
- **Burst read:**
  - Stimulus: OP=011, `Base`=0x00100, `Len`=3, memory preloaded 0x11,0x22,0x33,0x44.
  - Response: addresses 0x100..0x103 in T+1..T+4; `rd_valid` in T+2..T+5 with data in order; `done` at T+5.
- **Pattern with wrap:**
  - Stimulus: OP=101, `Base`=0xFFFFE, `Len`=3, `Wdata`=0xFE.
  - Response: writes (0xFFFFE,0xFE), (0xFFFFF,0xFF), (0x00000,0x00), (0x00001,0x01).
- **Max fill:**
  - Stimulus: OP=100, `Len`=255.
  - Response: exactly 256 consecutive `mem_we` cycles; `done` at T+257; `cmd_ready` low throughout.
- **Reset in the middle of a burst:**
  - Stimulus: OP=011, `Len`=7; assert `reset` in cycle T+3.
  - Response: all outputs 0 from the next edge; no `done`; new command accepted the cycle after `reset` falls.
- **Illegal OP=111:**
  - With `MEM_IF_ERR_EN`: `done`=`err`=1 at T+1, no strobes.
  - Without `MEM_IF_ERR_EN`: no `done`, `cmd_ready` stays 1.
